// File: rtl/poci_gpio.sv
`default_nettype none
// ============================================================================
// Module   : poci_gpio
// Purpose  : POCI general-purpose I/O slave. Synchronises and debounces up to
//            32 input pins, latches sticky rise/fall flags, raises a maskable
//            level interrupt and drives up to 32 output pins with atomic
//            set/clear access.
// Ports    : pclk, presetn            - clock, async active-low reset
//            paddr/pwrite/psel/penable/pwdata -> prdata/pready/pslverr
//                                      - POCI slave (no wait states)
//            gpio_in  [N_IN-1:0]      - raw asynchronous input pins
//            gpio_out [N_OUT-1:0]     - registered output pins
//            irq                      - registered level interrupt
// Revision : 1.0 - initial release
// ============================================================================
module poci_gpio #(
  parameter int                N_IN            = 14,
  parameter int                N_OUT           = 32,
  parameter int                DEBOUNCE_CYCLES = 240000,
  parameter logic [N_IN-1:0]   IN_INVERT       = 14'h000F,
  parameter logic [31:0]       OUT_RESET       = 32'h0
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic [31:0]       paddr,
  input  logic              pwrite,
  input  logic              psel,
  input  logic              penable,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [N_IN-1:0]   gpio_in,
  output logic [N_OUT-1:0]  gpio_out,
  output logic              irq
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] REG_IN      = 3'd0;
  localparam logic [2:0] REG_RISE    = 3'd1;
  localparam logic [2:0] REG_FALL    = 3'd2;
  localparam logic [2:0] REG_IRQ_EN  = 3'd3;
  localparam logic [2:0] REG_OUT     = 3'd4;
  localparam logic [2:0] REG_OUT_SET = 3'd5;
  localparam logic [2:0] REG_OUT_CLR = 3'd6;
  localparam logic [2:0] REG_RAW     = 3'd7;

  logic [N_IN-1:0]  r_meta;
  logic [N_IN-1:0]  r_sync;
  logic [N_IN-1:0]  r_deb;
  logic [N_IN-1:0]  r_rise;
  logic [N_IN-1:0]  r_fall;
  logic [N_IN-1:0]  r_irq_en;
  logic [N_OUT-1:0] r_out;
  logic             r_irq;

  logic [N_IN-1:0]  w_accept;
  logic [N_IN-1:0]  w_rise_evt;
  logic [N_IN-1:0]  w_fall_evt;
  logic [N_IN-1:0]  w_rise_clr;
  logic [N_IN-1:0]  w_fall_clr;
  logic [N_OUT-1:0] w_out_next;
  logic [31:0]      w_rdata;
  logic [2:0]       w_sel;
  logic             w_wr;
  logic             w_unused_bits;

  assign w_sel = paddr[4:2];
  assign w_wr  = psel & penable & pwrite;

  // Only the word offset is decoded; the remaining address bits and any
  // write-data bits beyond the implemented widths are deliberately ignored.
  assign w_unused_bits = ^{paddr[31:5], paddr[1:0], pwdata};

  // Inversion happens before the synchroniser so an idle active-low key
  // resets to the same level as the flops and produces no spurious edge.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= gpio_in ^ IN_INVERT;
      r_sync <= r_meta;
    end
  end

  // Per-bit debounce: count consecutive cycles of sync != deb; accept the new
  // level on the cycle the count reaches DEBOUNCE_CYCLES-1. Any agreement
  // restarts the count, so the counter never exceeds CNT_MAX.
  for (genvar i = 0; i < N_IN; i++) begin : g_deb
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
        r_cnt <= '0;
      end else if (r_sync[i] == r_deb[i]) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign w_accept[i] = (r_sync[i] != r_deb[i]) && (r_cnt == CNT_MAX);
  end

  assign w_rise_evt = w_accept & r_sync;
  assign w_fall_evt = w_accept & ~r_sync;

  assign w_rise_clr = (w_wr && (w_sel == REG_RISE)) ? pwdata[N_IN-1:0] : '0;
  assign w_fall_clr = (w_wr && (w_sel == REG_FALL)) ? pwdata[N_IN-1:0] : '0;

  // Flags: a new edge is OR-ed in after the W1C mask, so set beats clear.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_deb    <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
      r_irq_en <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_deb  <= r_deb ^ w_accept;
      r_rise <= (r_rise & ~w_rise_clr) | w_rise_evt;
      r_fall <= (r_fall & ~w_fall_clr) | w_fall_evt;
      if (w_wr && (w_sel == REG_IRQ_EN)) begin
        r_irq_en <= pwdata[N_IN-1:0];
      end
      r_irq  <= |((r_rise | r_fall) & r_irq_en);
    end
  end

  always_comb begin
    w_out_next = r_out;
    if (w_wr) begin
      case (w_sel)
        REG_OUT:     w_out_next = pwdata[N_OUT-1:0];
        REG_OUT_SET: w_out_next = r_out | pwdata[N_OUT-1:0];
        REG_OUT_CLR: w_out_next = r_out & ~pwdata[N_OUT-1:0];
        default:     w_out_next = r_out;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_out <= OUT_RESET[N_OUT-1:0];
    end else begin
      r_out <= w_out_next;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      REG_IN:     w_rdata = 32'(r_deb);
      REG_RISE:   w_rdata = 32'(r_rise);
      REG_FALL:   w_rdata = 32'(r_fall);
      REG_IRQ_EN: w_rdata = 32'(r_irq_en);
      REG_OUT:    w_rdata = 32'(r_out);
      REG_RAW:    w_rdata = 32'(r_sync);
      default:    w_rdata = '0;
    endcase
  end

  assign prdata   = (psel && penable) ? w_rdata : '0;
  assign pready   = 1'b1;
  assign pslverr  = 1'b0;
  assign gpio_out = r_out;
  assign irq      = r_irq;

endmodule
`default_nettype wire
